// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, mul/div FSM encoding, default width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] OP_MUL = 5'd10;
  localparam logic [4:0] OP_DIV = 5'd11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and keeps it if it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quot_nx
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_nx  = trial[WIDTH-1:0];
      quot_nx = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx  = shifted[WIDTH-1:0];
      quot_nx = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// Result is {HI,LO}; DIV returns {remainder, quotient}.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             op_div;

  // Booth accumulator keeps one guard bit so -2^(W-1) operands cannot overflow.
  logic [WIDTH:0]   acc_a;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] acc_q;
  logic             q_lsb;
  logic [WIDTH:0]   booth_sum;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quot_nx;
  logic             a_neg;
  logic             b_neg;

  logic             is_mul;
  logic             is_div;
  logic             accept;
  logic             b_zero;
  logic             last_iter;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_mul    = opcode == OP_MUL;
  assign is_div    = opcode == OP_DIV;
  assign accept    = (state == ST_IDLE) && start && (is_mul || is_div);
  assign b_zero    = input_b == '0;
  assign last_iter = cnt == CNT_W'(WIDTH - 1);
  assign abs_a     = input_a[WIDTH-1] ? -input_a : input_a;
  assign abs_b     = input_b[WIDTH-1] ? -input_b : input_b;
  assign q_fix     = (a_neg ^ b_neg) ? -quot : quot;
  assign r_fix     = a_neg ? -rem : rem;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem    (rem),
    .quot   (quot),
    .divisor(dvsr),
    .rem_nx (rem_nx),
    .quot_nx(quot_nx)
  );

  always_comb begin
    booth_sum = acc_a;
    case ({acc_q[0], q_lsb})
      2'b01:   booth_sum = acc_a + mcand;
      2'b10:   booth_sum = acc_a - mcand;
      default: booth_sum = acc_a;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_div && b_zero) state_nx = ST_DONE;
          else if (is_div)      state_nx = ST_DIV;
          else                  state_nx = ST_MUL;
        end
      end
      ST_MUL,
      ST_DIV:  if (last_iter) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
    end else begin
      state <= state_nx;
      busy  <= state_nx != ST_IDLE;
      done  <= state_nx == ST_DONE;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt    <= '0;
            op_div <= is_div;
            mcand  <= {input_a[WIDTH-1], input_a};
            acc_a  <= '0;
            acc_q  <= input_b;
            q_lsb  <= 1'b0;
            rem    <= '0;
            quot   <= abs_a;
            dvsr   <= abs_b;
            a_neg  <= input_a[WIDTH-1];
            b_neg  <= input_b[WIDTH-1];
            if (is_div && b_zero) begin
              result      <= {input_a, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          cnt   <= cnt + 1'b1;
          acc_a <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_q <= {booth_sum[0], acc_q[WIDTH-1:1]};
          q_lsb <= acc_q[0];
        end
        ST_DIV: begin
          cnt  <= cnt + 1'b1;
          rem  <= rem_nx;
          quot <= quot_nx;
        end
        ST_FIX: begin
          div_by_zero <= 1'b0;
          if (op_div) result <= {r_fix, q_fix};
          else        result <= {acc_a[WIDTH-1:0], acc_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results queued at accept,
// compared on each done pulse.
module tb_mul_div_unit;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  logic        clock;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] result;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   dn;
  exp_t sb[$];

  mul_div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .opcode     (opcode),
    .input_a    (input_a),
    .input_b    (input_b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .result     (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      exp_t e;
      dn++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  function automatic exp_t model(input logic [4:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint p;
    int q;
    int r;
    e.acc = 0;
    e.dz  = 1'b0;
    e.lat = 33;
    if (op == 5'd10) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.res = p;
    end else if (b == 32'd0) begin
      e.res = {a, 32'hFFFF_FFFF};
      e.dz  = 1'b1;
      e.lat = 0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = {32'd0, 32'h8000_0000};
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      e.res = {r, q};
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push,
                        input logic [63:0] res, input logic dz,
                        input int lat);
    exp_t e;
    start   = 1'b1;
    opcode  = op;
    input_a = a;
    input_b = b;
    @(posedge clock);
    #1;
    if (push) begin
      e.res = res;
      e.dz  = dz;
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clock);
    start   = 1'b0;
    input_a = $urandom;
    input_b = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clock);
  endtask

  initial begin
    int   d0;
    exp_t m;
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_cmp   = 0;
    n_bad   = 0;
    dn      = 0;
    clear   = 1'b1;
    start   = 1'b0;
    opcode  = 5'd0;
    input_a = 32'd0;
    input_b = 32'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_result", result, 64'd0);
    clear = 1'b0;
    @(negedge clock);

    launch(5'd10, -32'sd8, -32'sd3, 1, 64'd24, 1'b0, 33);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("result_hold", result, 64'd24);

    launch(5'd10, -32'sd6, 32'sd5, 1, 64'hFFFF_FFFF_FFFF_FFE2, 1'b0, 33);
    wait_done();
    launch(5'd10, 32'h8000_0000, 32'h8000_0000, 1,
           64'h4000_0000_0000_0000, 1'b0, 33);
    wait_done();
    launch(5'd11, -32'sd17, 32'sd5, 1,
           {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 1'b0, 33);
    wait_done();
    launch(5'd11, 32'd17, 32'd17, 1, {32'h0, 32'h1}, 1'b0, 33);
    wait_done();
    launch(5'd11, 32'd17, 32'd0, 1, {32'h0000_0011, 32'hFFFF_FFFF}, 1'b1, 0);
    wait_done();
    chk("dz_hold", {63'd0, div_by_zero}, 64'd1);
    launch(5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1,
           {32'h0, 32'h8000_0000}, 1'b0, 33);
    wait_done();

    launch(5'd10, 32'd2, 32'd3, 1, 64'd6, 1'b0, 33);
    repeat (3) @(negedge clock);
    start   = 1'b1;
    opcode  = 5'd11;
    input_a = 32'd100;
    input_b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    launch(5'd10, 32'd123, 32'd456, 0, 64'd0, 1'b0, 0);
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_busy", {63'd0, busy}, 64'd0);
    chk("clr_done", {63'd0, done}, 64'd0);
    chk("clr_result", result, 64'd0);
    d0 = dn;
    launch(5'd10, 32'd7, -32'sd9, 1, 64'hFFFF_FFFF_FFFF_FFC1, 1'b0, 33);
    wait_done();
    chk("one_done_after_clear", 64'(dn), 64'(d0 + 1));

    d0 = dn;
    start  = 1'b1;
    opcode = 5'd3;
    @(negedge clock);
    start = 1'b0;
    chk("bad_op_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clock);
    chk("bad_op_no_done", 64'(dn), 64'(d0));

    for (int i = 0; i < 10; i++) begin
      rop = (i % 2 == 0) ? 5'd10 : 5'd11;
      ra  = $urandom;
      rb  = (i == 7) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 50) : $urandom);
      if (i == 5) rb = -32'sd7;
      m = model(rop, ra, rb);
      launch(rop, ra, rb, 1, m.res, m.dz, m.lat);
      wait_done();
    end

    repeat (3) @(negedge clock);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
